saturating_counter_bank: RTL and testbench
==========================================

// Module: saturating_counter_bank
// PURPOSE
//  Bank of CHANNELS independent up/down counters that clamp to a programmable [COUNT_MIN, COUNT_MAX] range.
//  Each step is a variable amount, with a synchronous load and boundary flags per channel.
//  Used for credit tracking, confidence/predictor tables and occupancy meters that must never wrap.
//  Supersedes the single-channel unit-step saturating counter.
// PARAMETERS
//  CHANNELS     4                   number of independent counters
//  COUNT_WIDTH  4                   bits per counter value
//  STEP_WIDTH   2                   bits per step amount (step 0..2^STEP_WIDTH-1)
//  COUNT_MIN    0                   lower saturation bound
//  COUNT_MAX    2**COUNT_WIDTH-1    upper saturation bound; COUNT_MIN <= COUNT_MAX < 2**COUNT_WIDTH
//  RESET_VALUE  0                   count after reset; COUNT_MIN <= RESET_VALUE <= COUNT_MAX
// PORTS
//  clock       in   1                      clock, rising edge
//  resetn      in   1                      reset, asynchronous, active-low
//  increment   in   CHANNELS               per-channel increment request
//  decrement   in   CHANNELS               per-channel decrement request
//  step        in   CHANNELS*STEP_WIDTH    per-channel step amount; channel i at [i*STEP_WIDTH +: STEP_WIDTH]
//  load        in   CHANNELS               per-channel synchronous load
//  load_value  in   CHANNELS*COUNT_WIDTH   per-channel load value
//  count       out  CHANNELS*COUNT_WIDTH   per-channel registered count
//  is_min      out  CHANNELS               count == COUNT_MIN
//  is_max      out  CHANNELS               count == COUNT_MAX
// BEHAVIOUR
//  - Reset (asynchronous, any time, including mid-operation) sets every count to RESET_VALUE.
//    is_min and is_max then follow from RESET_VALUE.
//  - Channels are fully independent; there is no cross-channel interaction.
//  - Latency: a request sampled on edge N is visible on count after edge N. is_min/is_max decode the count register combinationally.
//  - Per-channel priority, evaluated each edge:
//    1. load: count <= clamp(load_value, COUNT_MIN, COUNT_MAX). Coincident increment/decrement is ignored.
//    2. increment && decrement: count unchanged; the requests cancel regardless of step.
//    3. increment: count <= min(count + step, COUNT_MAX).
//    4. decrement: count <= max(count - step, COUNT_MIN).
//    5. otherwise: hold.
//  - Arithmetic is done in COUNT_WIDTH+1 bits plus sign, so the sum or difference never wraps before clamping. step = 0 holds the count.
//  - Out-of-range parameters (ordering rules above violated) raise an elaboration-time error.
// CONFIGURATION
//  - Macro SATURATING_COUNTER_BANK_STICKY_FLAGS_EN.
//  - When defined, three ports are added:
//    overflow   out  CHANNELS  sticky; set when increment (without load or decrement) has count + step > COUNT_MAX
//    underflow  out  CHANNELS  sticky; set when decrement (without load or increment) has count - step < COUNT_MIN
//    clear_flags in  CHANNELS  clears that channel's overflow and underflow
//  - Flags set on the edge where clipping occurs. This includes a request made while already at the bound with step > 0.
//  - Set wins over clear in the same cycle. Reset clears both flags to 0.
//  - When not defined, these ports and flops are absent; counting behaviour is identical.
// TESTING
//  Defaults assumed unless noted (CHANNELS=4, COUNT_WIDTH=4, COUNT_MIN=0, COUNT_MAX=15).
//  1. Reset: count=0, is_min=1, is_max=0 on all channels; assert resetn low mid-count at 9 -> count=0 immediately, before the next edge.
//  2. Saturate up: ch0 count=14, increment, step=3 -> 15, is_max=1; repeat -> stays 15; overflow=1 (flags build).
//  3. Saturate down with bounds MIN=2, MAX=12: count=3, decrement, step=2 -> 2; again -> 2, is_min=1, underflow=1.
//  4. Simultaneous: increment+decrement, step=3, count=7 -> 7; load=1, load_value=13 with increment -> 13 (with MAX=12 -> 12).
//  5. Independence: ch1 increment step=1 and ch2 decrement step=2 in the same cycle from 5 -> ch1=6, ch2=3, ch0/ch3 unchanged.
//  6. Flags: overflow set and clear_flags in same cycle -> overflow=1; clear_flags alone next cycle -> 0; step=0 at max -> no flag.

Source files
------------

// File: rtl/saturating_counter_bank.sv
// Bank of independent up/down counters clamped to [COUNT_MIN, COUNT_MAX] with load and bound flags.
// Define SATURATING_COUNTER_BANK_STICKY_FLAGS_EN to add sticky overflow/underflow flags.
module saturating_counter_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned STEP_WIDTH  = 2,
    parameter int unsigned COUNT_MIN   = 0,
    parameter int unsigned COUNT_MAX   = 2 ** COUNT_WIDTH - 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [CHANNELS-1:0]             increment,
    input  logic [CHANNELS-1:0]             decrement,
    input  logic [CHANNELS*STEP_WIDTH-1:0]  step,
    input  logic [CHANNELS-1:0]             load,
    input  logic [CHANNELS*COUNT_WIDTH-1:0] load_value,
    output logic [CHANNELS*COUNT_WIDTH-1:0] count,
    output logic [CHANNELS-1:0]             is_min,
    output logic [CHANNELS-1:0]             is_max
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
    ,
    output logic [CHANNELS-1:0]             overflow,
    output logic [CHANNELS-1:0]             underflow,
    input  logic [CHANNELS-1:0]             clear_flags
`endif
);

    // Signed working width: wide enough that count +/- step never wraps before clamping.
    localparam int unsigned AW = ((COUNT_WIDTH > STEP_WIDTH) ? COUNT_WIDTH : STEP_WIDTH) + 2;

    localparam logic signed [AW-1:0]   MinS = AW'(COUNT_MIN);
    localparam logic signed [AW-1:0]   MaxS = AW'(COUNT_MAX);
    localparam logic [COUNT_WIDTH-1:0] MinC = COUNT_WIDTH'(COUNT_MIN);
    localparam logic [COUNT_WIDTH-1:0] MaxC = COUNT_WIDTH'(COUNT_MAX);
    localparam logic [COUNT_WIDTH-1:0] RstC = COUNT_WIDTH'(RESET_VALUE);

    if (COUNT_MAX >= 2 ** COUNT_WIDTH || COUNT_MIN > COUNT_MAX ||
        RESET_VALUE < COUNT_MIN || RESET_VALUE > COUNT_MAX) begin : g_param_err
        $error("saturating_counter_bank: illegal COUNT_MIN/COUNT_MAX/RESET_VALUE");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic signed [AW-1:0]   cur, stp, ldv, sum, diff;

        assign cur  = AW'(cnt_q);
        assign stp  = AW'(step[i*STEP_WIDTH +: STEP_WIDTH]);
        assign ldv  = AW'(load_value[i*COUNT_WIDTH +: COUNT_WIDTH]);
        assign sum  = cur + stp;
        assign diff = cur - stp;

        // Load beats everything; coincident increment and decrement cancel.
        always_comb begin
            cnt_d = cnt_q;
            if (load[i]) begin
                if (ldv > MaxS) begin
                    cnt_d = MaxC;
                end else if (ldv < MinS) begin
                    cnt_d = MinC;
                end else begin
                    cnt_d = ldv[COUNT_WIDTH-1:0];
                end
            end else if (increment[i] && !decrement[i]) begin
                cnt_d = (sum > MaxS) ? MaxC : sum[COUNT_WIDTH-1:0];
            end else if (decrement[i] && !increment[i]) begin
                cnt_d = (diff < MinS) ? MinC : diff[COUNT_WIDTH-1:0];
            end
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= RstC;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
        assign is_min[i] = (cnt_q == MinC);
        assign is_max[i] = (cnt_q == MaxC);

`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        logic ovf_q, unf_q, ovf_set, unf_set;

        assign ovf_set = increment[i] && !decrement[i] && !load[i] && (sum > MaxS);
        assign unf_set = decrement[i] && !increment[i] && !load[i] && (diff < MinS);

        // Set wins over a same-cycle clear.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_set | (ovf_q & ~clear_flags[i]);
                unf_q <= unf_set | (unf_q & ~clear_flags[i]);
            end
        end

        assign overflow[i]  = ovf_q;
        assign underflow[i] = unf_q;
`endif
    end

endmodule

// File: tb/tb_saturating_counter_bank.sv
// Scoreboard bench for saturating_counter_bank: default instance plus a MIN=2/MAX=12 instance.
module tb_saturating_counter_bank;

    localparam int CH = 4;

    logic        clock;
    logic        resetn;
    logic [3:0]  increment, decrement, load;
    logic [7:0]  step;
    logic [15:0] load_value;
    logic [15:0] count_a, count_b;
    logic [3:0]  is_min_a, is_max_a, is_min_b, is_max_b;
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
    logic [3:0]  clear_flags;
    logic [3:0]  overflow_a, underflow_a, overflow_b, underflow_b;
`endif

    saturating_counter_bank dut_a (
        .clock      (clock),
        .resetn     (resetn),
        .increment  (increment),
        .decrement  (decrement),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .count      (count_a),
        .is_min     (is_min_a),
        .is_max     (is_max_a)
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        ,
        .overflow   (overflow_a),
        .underflow  (underflow_a),
        .clear_flags(clear_flags)
`endif
    );

    saturating_counter_bank #(
        .COUNT_MIN  (2),
        .COUNT_MAX  (12),
        .RESET_VALUE(2)
    ) dut_b (
        .clock      (clock),
        .resetn     (resetn),
        .increment  (increment),
        .decrement  (decrement),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .count      (count_b),
        .is_min     (is_min_b),
        .is_max     (is_max_b)
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        ,
        .overflow   (overflow_b),
        .underflow  (underflow_b),
        .clear_flags(clear_flags)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ca, cb;
        logic [3:0]  mina, maxa, minb, maxb;
        logic [3:0]  ova, uda, ovb, udb;
    } exp_t;

    exp_t sb[$];
    int   m_a[CH], m_b[CH];
    logic [3:0] f_ova, f_uda, f_ovb, f_udb;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int model_next(int c, bit inc, bit dec, bit ld, int s, int lv,
                                      int lo, int hi);
        if (ld) return clampi(lv, lo, hi);
        if (inc && dec) return c;
        if (inc) return clampi(c + s, lo, hi);
        if (dec) return clampi(c - s, lo, hi);
        return c;
    endfunction

    function automatic exp_t pack_model();
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            e.ca[c*4 +: 4] = 4'(m_a[c]);
            e.cb[c*4 +: 4] = 4'(m_b[c]);
            e.mina[c] = (m_a[c] == 0);
            e.maxa[c] = (m_a[c] == 15);
            e.minb[c] = (m_b[c] == 2);
            e.maxb[c] = (m_b[c] == 12);
        end
        e.ova = f_ova; e.uda = f_uda; e.ovb = f_ovb; e.udb = f_udb;
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_a[c] = 0;
            m_b[c] = 2;
        end
        f_ova = '0; f_uda = '0; f_ovb = '0; f_udb = '0;
    endtask

    task automatic compare(input exp_t e);
        check("count_a", 32'(count_a), 32'(e.ca));
        check("is_min_a", 32'(is_min_a), 32'(e.mina));
        check("is_max_a", 32'(is_max_a), 32'(e.maxa));
        check("count_b", 32'(count_b), 32'(e.cb));
        check("is_min_b", 32'(is_min_b), 32'(e.minb));
        check("is_max_b", 32'(is_max_b), 32'(e.maxb));
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        check("overflow_a", 32'(overflow_a), 32'(e.ova));
        check("underflow_a", 32'(underflow_a), 32'(e.uda));
        check("overflow_b", 32'(overflow_b), 32'(e.ovb));
        check("underflow_b", 32'(underflow_b), 32'(e.udb));
`endif
    endtask

    // Advance the model with the currently driven inputs, push, clock, then pop and compare.
    task automatic cycle();
        exp_t e;
        logic [3:0] clr;
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        clr = clear_flags;
`else
        clr = '0;
`endif
        for (int c = 0; c < CH; c++) begin
            bit inc, dec, ld;
            int s, lv;
            inc = increment[c];
            dec = decrement[c];
            ld  = load[c];
            s   = int'(step[c*2 +: 2]);
            lv  = int'(load_value[c*4 +: 4]);
            f_ova[c] = (inc && !dec && !ld && (m_a[c] + s > 15)) || (f_ova[c] && !clr[c]);
            f_uda[c] = (dec && !inc && !ld && (m_a[c] - s < 0))  || (f_uda[c] && !clr[c]);
            f_ovb[c] = (inc && !dec && !ld && (m_b[c] + s > 12)) || (f_ovb[c] && !clr[c]);
            f_udb[c] = (dec && !inc && !ld && (m_b[c] - s < 2))  || (f_udb[c] && !clr[c]);
            m_a[c] = model_next(m_a[c], inc, dec, ld, s, lv, 0, 15);
            m_b[c] = model_next(m_b[c], inc, dec, ld, s, lv, 2, 12);
        end
        sb.push_back(pack_model());
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            compare(e);
        end
    endtask

    task automatic idle();
        increment  = '0;
        decrement  = '0;
        load       = '0;
        step       = '0;
        load_value = '0;
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        clear_flags = '0;
`endif
    endtask

    task automatic drive(input int c, input bit inc, input bit dec, input int st,
                         input bit ld, input int lv);
        increment[c]       = inc;
        decrement[c]       = dec;
        step[c*2 +: 2]     = 2'(st);
        load[c]            = ld;
        load_value[c*4 +: 4] = 4'(lv);
    endtask

    task automatic set_clear(input logic [3:0] v);
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
        clear_flags = v;
`else
        if (v != 4'h0) idle();
`endif
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        model_reset();
        #12;
        compare(pack_model());
        @(negedge clock);
        resetn = 1'b1;

        // Saturate up on ch0, then clear/set interplay and step 0 at max.
        drive(0, 0, 0, 0, 1, 14); cycle(); idle();
        drive(0, 1, 0, 3, 0, 0);  cycle();
        cycle();
        set_clear(4'b0001);       cycle(); idle();
        set_clear(4'b0001);       cycle(); idle();
        drive(0, 1, 0, 0, 0, 0);  cycle(); idle();

        // Saturate down on ch0.
        drive(0, 0, 0, 0, 1, 3);  cycle(); idle();
        drive(0, 0, 1, 2, 0, 0);  cycle();
        cycle(); idle();

        // Cancelling requests and load priority on all channels.
        for (int c = 0; c < CH; c++) drive(c, 0, 0, 0, 1, 7);
        cycle(); idle();
        for (int c = 0; c < CH; c++) drive(c, 1, 1, 3, 0, 0);
        cycle(); idle();
        for (int c = 0; c < CH; c++) drive(c, 1, 0, 3, 1, 13);
        cycle(); idle();

        // Channel independence.
        for (int c = 0; c < CH; c++) drive(c, 0, 0, 0, 1, 5);
        cycle(); idle();
        drive(1, 1, 0, 1, 0, 0);
        drive(2, 0, 1, 2, 0, 0);
        cycle(); idle();

        // Asynchronous reset mid-count, observed before the next edge.
        drive(0, 0, 0, 0, 1, 9); cycle(); idle();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare(pack_model());
        @(negedge clock);
        resetn = 1'b1;

        for (int n = 0; n < 300; n++) begin
            increment  = 4'($urandom);
            decrement  = 4'($urandom);
            step       = 8'($urandom);
            load       = 4'($urandom) & 4'($urandom) & 4'($urandom);
            load_value = 16'($urandom);
`ifdef SATURATING_COUNTER_BANK_STICKY_FLAGS_EN
            clear_flags = 4'($urandom) & 4'($urandom);
`endif
            cycle();
        end
        idle();

        if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
